// File: rtl/int_cntrl_block_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// reset vector values and the CPU-side register request bundle.
package int_cntrl_block_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int WIN_WORDS   = 8;

  // Word offsets from BASE_ADDR
  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_PEND = 3'd1;
  localparam logic [2:0] OFF_ISR  = 3'd2;
  localparam logic [2:0] OFF_VEC0 = 3'd4;

  localparam logic [15:0] VEC_RST_BASE = 16'h0010;
  localparam logic [15:0] VEC_RST_STEP = 16'h0004;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mm_req_t;

  // Reset value of the ISR vector for source n
  function automatic logic [15:0] vec_rst(input int n);
    return VEC_RST_BASE + VEC_RST_STEP * 16'(n);
  endfunction

endpackage

// File: rtl/int_cntrl_block_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module int_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan high to low so the last hit (lowest index) is the one that sticks
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/int_cntrl_block.sv
// Interrupt controller: edge-detects the request lines into PEND, dispatches
// one enabled source at a time (no nesting) to the CPU with its ISR vector,
// and exposes CTRL/PEND/ISR/VEC registers through a memory-mapped window.
// rst_n is active-high despite the name.
module int_cntrl_block
  import int_cntrl_block_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int          NUM_SRC   = NUM_SRC_DEF  // register map fits at most 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] int_src,
  input  logic               stall_IM_ID,
  input  logic [15:0]        mm_addr,
  input  logic               mm_we,
  input  logic [15:0]        mm_wdata,
  output logic [15:0]        mm_rdata,
  output logic               int_occurred,
  output logic [15:0]        int_vec
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  mm_req_t req;
  assign req = '{we: mm_we, addr: mm_addr, wdata: mm_wdata};

  logic [15:0] off_full;
  logic        in_win;
  logic [2:0]  off;

  assign off_full = req.addr - BASE_ADDR;
  assign in_win   = off_full < 16'(WIN_WORDS);
  assign off      = off_full[2:0];

  logic               wr_ctrl, wr_pend, wr_eoi;
  logic [NUM_SRC-1:0] wr_vec;

  assign wr_ctrl = req.we & in_win & (off == OFF_CTRL);
  assign wr_pend = req.we & in_win & (off == OFF_PEND);
  assign wr_eoi  = req.we & in_win & (off == OFF_ISR);

  // State
  logic [NUM_SRC-1:0]       src_s, src_d;   // sampled request, and one cycle older
  logic                     gie;
  logic [NUM_SRC-1:0]       ien, pend, isr;
  logic                     busy;
  logic [NUM_SRC-1:0][15:0] vec;

  // Per-source vector registers
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_vec
    assign wr_vec[g] = req.we & in_win & (off == OFF_VEC0 + 3'(g));

    // Software-loadable ISR address, reset to its default slot
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)          vec[g] <= vec_rst(g);
      else if (wr_vec[g]) vec[g] <= req.wdata;
    end
  end

  // Dispatch selection
  logic [NUM_SRC-1:0] cand, grant, rise;
  logic [IW-1:0]      gidx;
  logic               any, disp;

  assign cand = pend & ien;
  assign rise = src_s & ~src_d;

  int_prio_enc #(.N(NUM_SRC), .IW(IW)) u_prio (
    .req   (cand),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  // An EOI write in the same cycle defers dispatch by one cycle
  assign disp = gie & ~busy & ~stall_IM_ID & any & ~wr_eoi;

  // Edge detect, pending/in-service bookkeeping and registered dispatch outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      src_s        <= '0;
      src_d        <= '0;
      gie          <= 1'b0;
      ien          <= '0;
      pend         <= '0;
      isr          <= '0;
      busy         <= 1'b0;
      int_occurred <= 1'b0;
      int_vec      <= '0;
    end else begin
      src_s <= int_src;
      src_d <= src_s;
      // New edges are OR-ed in last so a hardware set beats any clear
      pend  <= (pend & ~(wr_pend ? req.wdata[NUM_SRC-1:0] : '0)
                     & ~(disp ? grant : '0)) | rise;
      if (wr_ctrl) begin
        gie <= req.wdata[15];
        ien <= req.wdata[NUM_SRC-1:0];
      end
      int_occurred <= disp;
      if (disp) begin
        int_vec <= vec[gidx];
        isr     <= grant;
        busy    <= 1'b1;
      end else if (wr_eoi) begin
        isr  <= '0;
        busy <= 1'b0;
      end
    end
  end

  // Register window read mux; offset 3 and unused VEC slots read zero
  always_comb begin
    mm_rdata = '0;
    if (in_win) begin
      case (off)
        OFF_CTRL: mm_rdata = {gie, 15'(ien)};
        OFF_PEND: mm_rdata = 16'(pend);
        OFF_ISR:  mm_rdata = {busy, 15'(isr)};
        default:  if (off[2] && (int'(off[1:0]) < NUM_SRC)) mm_rdata = vec[off[1:0]];
      endcase
    end
  end

endmodule

// File: tb/tb_int_cntrl_block.sv
// Bench for int_cntrl_block: directed scenarios plus randomized traffic, with
// a per-cycle scoreboard fed by a behavioural model of the controller.
module tb_int_cntrl_block;

  localparam logic [15:0] BASE = 16'hC000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  int_src = '0;
  logic        stall_IM_ID = 1'b0;
  logic [15:0] mm_addr = '0;
  logic        mm_we = 1'b0;
  logic [15:0] mm_wdata = '0;
  logic [15:0] mm_rdata;
  logic        int_occurred;
  logic [15:0] int_vec;

  int_cntrl_block #(.BASE_ADDR(BASE), .NUM_SRC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .int_src      (int_src),
    .stall_IM_ID  (stall_IM_ID),
    .mm_addr      (mm_addr),
    .mm_we        (mm_we),
    .mm_wdata     (mm_wdata),
    .mm_rdata     (mm_rdata),
    .int_occurred (int_occurred),
    .int_vec      (int_vec)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] A(input int o);
    return 16'(int'(BASE) + o);
  endfunction

  // ---------------- behavioural reference model ----------------
  logic        m_gie, m_busy, m_occ;
  logic [3:0]  m_ien, m_pend, m_isr, m_h1, m_h2;
  logic [15:0] m_vec [4];
  logic [15:0] m_ivec;

  task automatic m_reset();
    m_gie = 0; m_ien = 0; m_pend = 0; m_isr = 0; m_busy = 0;
    m_occ = 0; m_ivec = 0; m_h1 = 0; m_h2 = 0;
    for (int i = 0; i < 4; i++) m_vec[i] = 16'h0010 + 16'(4 * i);
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off < 0 || off > 7) return 16'h0000;
    case (off)
      0: return {m_gie, 11'b0, m_ien};
      1: return {12'b0, m_pend};
      2: return {m_busy, 11'b0, m_isr};
      3: return 16'h0000;
      default: return m_vec[off - 4];
    endcase
  endfunction

  // What the controller does at the coming clock edge with the inputs now applied
  task automatic m_advance();
    int         off, n;
    bit         inwin, eoi;
    logic [3:0] rise, ready, nxt;
    if (rst_n) begin
      m_reset();
      return;
    end
    off   = int'(mm_addr) - int'(BASE);
    inwin = (off >= 0) && (off <= 7);
    eoi   = mm_we && inwin && off == 2;
    // a 0->1 step between the two most recent samples becomes pending now
    rise  = m_h1 & ~m_h2;
    m_h2  = m_h1;
    m_h1  = int_src;
    ready = m_pend & m_ien;
    nxt   = m_pend;
    m_occ = 0;
    if (m_gie && !m_busy && !stall_IM_ID && ready != 0 && !eoi) begin
      n = 0;
      while (!ready[n]) n++;
      m_occ    = 1;
      m_ivec   = m_vec[n];
      nxt[n]   = 1'b0;
      m_isr    = 4'(1 << n);
      m_busy   = 1;
    end else if (eoi) begin
      m_isr  = 0;
      m_busy = 0;
    end
    if (mm_we && inwin && off == 1) nxt = nxt & ~mm_wdata[3:0];
    m_pend = nxt | rise;
    if (mm_we && inwin && off == 0) begin
      m_gie = mm_wdata[15];
      m_ien = mm_wdata[3:0];
    end
    if (mm_we && inwin && off >= 4) m_vec[off - 4] = mm_wdata;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] rd;
    logic        occ;
    logic [15:0] vec;
  } exp_t;
  exp_t q[$];

  logic [3:0] cur_src = '0;
  logic       cur_stall = 1'b0;
  logic       cur_rst = 1'b1;

  // Drive this cycle's inputs, record the expected outputs, then step the model
  task automatic apply(input logic we, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    rst_n = cur_rst; int_src = cur_src; stall_IM_ID = cur_stall;
    mm_we = we; mm_addr = a; mm_wdata = d;
    if (rst_n) m_reset();
    e.rd = m_read(a); e.occ = m_occ; e.vec = m_ivec;
    q.push_back(e);
    m_advance();
  endtask

  task automatic cycle(input logic we, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    apply(we, a, d);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_rdata", mm_rdata, e.rd);
      chk("sb_occurred", 16'(int_occurred), 16'(e.occ));
      chk("sb_int_vec", int_vec, e.vec);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic rd(input string name, input int o, input logic [15:0] exp);
    cycle(0, A(o), 16'h0);
    #1;
    chk(name, mm_rdata, exp);
  endtask

  task automatic wait_pulse(input string name, input logic [15:0] exp, input int maxc);
    bit got;
    got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      cycle(0, A(1), 16'h0);
      #1;
      got = int_occurred;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL %s: no int_occurred within %0d cycles", name, maxc);
    end else chk(name, int_vec, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rst_tbl [8];
    int cnt, r, k, o;
    rst_tbl = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0014, 16'h0018, 16'h001C};
    m_reset();

    // reset values and window bounds
    cur_rst = 1; cycle(0, 16'h0, 16'h0); cycle(0, 16'h0, 16'h0);
    cur_rst = 0; cycle(0, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) rd($sformatf("reset_reg%0d", i), i, rst_tbl[i]);
    rd("outside_hi", 8, 16'h0);
    rd("outside_lo", -1, 16'h0);
    cycle(0, 16'h0000, 16'h0); #1; chk("outside_zero", mm_rdata, 16'h0);

    // single source, exact latency
    cycle(1, A(0), 16'h8002);
    cur_src = 4'b0010; cycle(0, A(1), 16'h0);
    cycle(0, A(1), 16'h0); #1; chk("lat_c1", 16'(int_occurred), 16'h0);
    cycle(0, A(1), 16'h0); #1; chk("lat_c2", 16'(int_occurred), 16'h0);
    cycle(0, A(1), 16'h0); #1;
    chk("lat_c3", 16'(int_occurred), 16'h1);
    chk("vec_src1", int_vec, 16'h0014);
    chk("pend_cleared", mm_rdata, 16'h0);
    cycle(0, A(2), 16'h0); #1;
    chk("pulse_width", 16'(int_occurred), 16'h0);
    chk("isr_src1", mm_rdata, 16'h8002);
    chk("vec_hold", int_vec, 16'h0014);
    cycle(1, A(2), 16'h0); cur_src = 4'b0000;

    // priority and no nesting
    cycle(1, A(0), 16'h800F); cur_src = 4'b1001;
    wait_pulse("prio_src0", 16'h0010, 8);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin cycle(0, A(1), 16'h0); #1; cnt += int'(int_occurred); end
    chk("no_nest", 16'(cnt), 16'h0);
    chk("pend_waiting", mm_rdata, 16'h0008);
    cycle(1, A(2), 16'h0);
    cycle(0, A(1), 16'h0); #1; chk("eoi_defers", 16'(int_occurred), 16'h0);
    wait_pulse("after_eoi_src3", 16'h001C, 8);
    cycle(1, A(2), 16'h0); cur_src = 4'b0000;
    cycle(0, A(1), 16'h0);

    // stall inhibits dispatch
    cur_stall = 1; cur_src = 4'b0100;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin cycle(0, A(1), 16'h0); #1; cnt += int'(int_occurred); end
    chk("stall_no_pulse", 16'(cnt), 16'h0);
    cur_stall = 0;
    cycle(0, A(1), 16'h0); #1; chk("stall_edge", 16'(int_occurred), 16'h0);
    cycle(0, A(1), 16'h0); #1;
    chk("stall_release", 16'(int_occurred), 16'h1);
    chk("stall_vec", int_vec, 16'h0018);

    // masked source, W1C, set beats clear
    cycle(1, A(2), 16'h0); cur_src = 4'b0000;
    cycle(0, A(1), 16'h0); cycle(0, A(1), 16'h0);
    cycle(1, A(0), 16'h8000);
    cur_src = 4'b0100;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin cycle(0, A(1), 16'h0); #1; cnt += int'(int_occurred); end
    chk("pend_masked", mm_rdata, 16'h0004);
    chk("masked_no_pulse", 16'(cnt), 16'h0);
    cycle(1, A(1), 16'h0004);
    cycle(0, A(1), 16'h0); #1; chk("w1c", mm_rdata, 16'h0);
    cur_src = 4'b0000; cycle(0, A(1), 16'h0); cycle(0, A(1), 16'h0);
    cur_src = 4'b0100; cycle(0, A(1), 16'h0);
    cycle(1, A(1), 16'h0004);
    cycle(0, A(1), 16'h0); #1; chk("set_wins", mm_rdata, 16'h0004);
    cycle(1, A(1), 16'h0004);

    // reset during a dispatch pulse
    cycle(1, A(0), 16'h800F);
    cycle(1, A(5), 16'h1234);
    cycle(1, A(2), 16'h0);
    cur_src = 4'b0000; cycle(0, A(1), 16'h0); cycle(0, A(1), 16'h0);
    cur_src = 4'b0010; cycle(0, A(1), 16'h0);
    cycle(0, A(1), 16'h0); cycle(0, A(1), 16'h0);
    @(posedge clk); #1;
    chk("rst_pre_occ", 16'(int_occurred), 16'h1);
    chk("rst_pre_vec", int_vec, 16'h1234);
    cur_rst = 1; apply(0, A(5), 16'h0); #1;
    chk("rst_occ", 16'(int_occurred), 16'h0);
    chk("rst_vec", int_vec, 16'h0);
    chk("rst_vec1_reg", mm_rdata, 16'h0014);
    cycle(0, A(1), 16'h0); #1; chk("rst_pend", mm_rdata, 16'h0);
    cur_rst = 0; cur_src = 4'b0000;
    rd("rst_ctrl", 0, 16'h0);
    rd("rst_isr", 2, 16'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cur_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) cur_src = cur_src ^ 4'(1 << $urandom_range(0, 3));
      cur_stall = ($urandom_range(0, 4) == 0);
      k = $urandom_range(0, 19);
      r = int'($urandom_range(0, 65535));
      case (k)
        0, 1: cycle(1, A(0), {1'($urandom_range(0, 3) != 0), 15'(r)});
        2, 3: cycle(1, A(2), 16'(r));
        4:    cycle(1, A(1), 16'(r));
        5:    cycle(1, A(int'($urandom_range(4, 7))), 16'(r));
        6: begin
          o = ($urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(8, 40));
          if ($urandom_range(0, 3) == 0) o = -int'($urandom_range(1, 20));
          cycle(1, A(o), 16'(r));
        end
        7:    cycle(0, 16'($urandom), 16'(r));
        default: cycle(0, A(int'($urandom_range(0, 9))), 16'(r));
      endcase
    end
    cur_rst = 0;
    cycle(0, A(1), 16'h0); cycle(0, A(1), 16'h0);
    @(negedge clk); #1;
    chk("sb_drained", 16'(q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/int_cntrl_block.md
INT_CNTRL_BLOCK -- requirements
Module: int_cntrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hC000, base of the memory-mapped register window.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of interrupt sources (only 4 required).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-high (asserted when 1); name kept per codebase convention.
REQ-005 SHALL have port int_src  input  4  interrupt request lines, level inputs, bit 0 = source 0.
REQ-006 SHALL have port stall_IM_ID  input  1  CPU fetch/decode stall; dispatch inhibited while 1.
REQ-007 SHALL have port mm_addr  input  16  CPU memory-mapped address.
REQ-008 SHALL have port mm_we  input  1  CPU memory-mapped write strobe.
REQ-009 SHALL have port mm_wdata  input  16  CPU write data.
REQ-010 SHALL have port mm_rdata  output  16  read data for the register window; combinational from mm_addr.
REQ-011 SHALL have port int_occurred  output  1  one-cycle registered dispatch pulse to CPU.
REQ-012 SHALL have port int_vec  output  16  ISR address for the dispatched source.

Function
REQ-013 Register map, word offsets from BASE_ADDR: +0 CTRL (bit15 GIE, bits3:0 IEN mask, others read 0); +1 PEND (bits3:0); +2 ISR (bits3:0 one-hot in-service, bit15 busy); +4..+7 VEC0..VEC3.
REQ-014 Rising edge of int_src[n], detected against a 1-cycle registered copy, SHALL set PEND[n] on the following clock edge.
REQ-015 Writing PEND SHALL clear each bit written as 1 (write-1-to-clear); if a hardware set and a software clear hit the same bit in one cycle, set wins.
REQ-016 Any write to ISR (offset +2) SHALL be end-of-interrupt: clear all in-service bits and busy.
REQ-017 Writes to CTRL and VECn SHALL load mm_wdata fully (CTRL unused bits ignored).
REQ-018 Dispatch condition: GIE=1, busy=0, stall_IM_ID=0, and (PEND & IEN) != 0.
REQ-019 On dispatch, priority SHALL be fixed, lowest index highest; selected source n: int_occurred=1 for exactly one cycle, int_vec=VECn, PEND[n] cleared, ISR[n] and busy set.
REQ-020 int_vec SHALL hold its value until the next dispatch.
REQ-021 No nesting: no dispatch while busy=1; pending requests wait and are dispatched after EOI in priority order.
REQ-022 Latency: int_src rising at edge k -> PEND set at edge k+1 -> int_occurred high in the cycle after edge k+2 (if REQ-018 holds).
REQ-023 mm_rdata SHALL return the addressed register for offsets +0..+7 (offsets +3 reading 0) and 16'h0000 outside the window.
REQ-024 Writes outside the window SHALL have no effect; mm_we without a valid offset is ignored.
REQ-025 An EOI write and a dispatch condition in the same cycle: EOI takes effect, dispatch occurs on the next cycle at the earliest.

Reset
REQ-026 While rst_n=1: CTRL=0, PEND=0, ISR/busy=0, edge-detect registers=0, int_occurred=0, int_vec=0, VECn=16'h0010+4*n.
REQ-027 Reset asserted mid-dispatch SHALL immediately drop int_occurred and discard pending/in-service state.

Structure
REQ-028 Register offsets, reset vector values and NUM_SRC default SHALL live in a shared package used by int_cntrl and the CPU software headers.
REQ-029 A single sub-module, int_prio_enc (4-bit fixed-priority encoder producing one-hot grant and index), is natural; all else is flat.

Verification
REQ-030 Reset, read BASE+0..+7 -> 0,0,0,0,0x0010,0x0014,0x0018,0x001C; outside-window read -> 0.
REQ-031 Write CTRL=0x8002, raise int_src[1] -> int_occurred one-cycle pulse two cycles later, int_vec=0x0014, PEND=0, ISR=0x8002.
REQ-032 CTRL=0x800F, raise int_src[3] and int_src[0] together -> source 0 dispatched first (int_vec 0x0010); no second pulse until EOI write; after EOI source 3 dispatched (0x001C).
REQ-033 Pending enabled source with stall_IM_ID=1 for 5 cycles -> no pulse; pulse in the cycle after stall drops.
REQ-034 IEN=0 with int_src[2] edge -> PEND=0x0004, no dispatch; write PEND=0x0004 -> PEND=0; simultaneous edge and clear -> bit stays 1.
REQ-035 Assert rst_n during int_occurred pulse -> outputs 0 immediately, registers at reset values.
